// File: rtl/decoder_scan_pkg.sv
// rtl/decoder_scan_pkg.sv - shared types and defaults for the decoder channel scanner
package decoder_scan_pkg;

  localparam int SEL_W_DEF   = 3;
  localparam int DWELL_W_DEF = 8;
  localparam int NUM_CH      = 2 ** SEL_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/scan_next_ch.sv
// rtl/scan_next_ch.sv - priority search for the next enabled channel above cur and the lowest enabled channel
module scan_next_ch #(
  parameter int SEL_W = 3
) (
  input  logic [2**SEL_W-1:0] mask,
  input  logic [SEL_W-1:0]    cur,
  output logic [SEL_W-1:0]    next_ch,
  output logic                found,
  output logic [SEL_W-1:0]    low_ch,
  output logic                mask_zero
);

  localparam int NCH = 2 ** SEL_W;

  // Descending walk: the last hit written is the lowest qualifying index.
  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    low_ch  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_ch = SEL_W'(i);
        if (i > int'(cur)) begin
          next_ch = SEL_W'(i);
          found   = 1'b1;
        end
      end
    end
  end

  assign mask_zero = ~|mask;

endmodule

// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - sequencer stepping a 3-to-8 decoder through masked channels with dwell and gap
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode_cont,
  input  logic [2**SEL_W-1:0]   ch_mask,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [SEL_W-1:0]      sel,
  output logic                  en,
  output logic                  busy,
  output logic                  done
);

  localparam int NCH = 2 ** SEL_W;

  state_t             state_q, state_d;
  logic [NCH-1:0]     mask_q;
  logic [DWELL_W-1:0] dwell_q, cnt_q, cnt_d;
  logic               mode_q;
  logic [SEL_W-1:0]   sel_d;
  logic               en_d, busy_d, done_d, load;

  logic [NCH-1:0]     srch_mask;
  logic [SEL_W-1:0]   next_ch, low_ch;
  logic               found, mask_zero;

  // In IDLE the decision is made on the live mask so the first channel is up one cycle after start.
  assign srch_mask = (state_q == ST_IDLE) ? ch_mask : mask_q;

  scan_next_ch #(.SEL_W(SEL_W)) u_next (
    .mask      (srch_mask),
    .cur       (sel),
    .next_ch   (next_ch),
    .found     (found),
    .low_ch    (low_ch),
    .mask_zero (mask_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel     <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      en      <= en_d;
      busy    <= busy_d;
      done    <= done_d;
      cnt_q   <= cnt_d;
      if (load) begin
        mask_q  <= ch_mask;
        dwell_q <= dwell;
        mode_q  <= mode_cont;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    en_d    = en;
    busy_d  = busy;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          load = 1'b1;
          if (mask_zero) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
            sel_d   = low_ch;
            en_d    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      ST_ACTIVE: begin
        if (stop) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == dwell_q) begin
          en_d = 1'b0;
          if (found) begin
            state_d = ST_GAP;
            sel_d   = next_ch;
          end else if (mode_q) begin
            state_d = ST_GAP;
            sel_d   = low_ch;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_ACTIVE;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - self-checking bench for decoder_scan_ctrl
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode_cont = 1'b0;
  logic [7:0] ch_mask = '0;
  logic [7:0] dwell = '0;
  logic [2:0] sel;
  logic       en, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode_cont (mode_cont),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .sel       (sel),
    .en        (en),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic [2:0] esel;
    logic       een;
    logic       ebusy;
    logic       edone;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] o;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  // Behavioural 3-to-8 decoder that the sequencer drives downstream.
  function automatic logic [7:0] dec(input logic [2:0] s, input logic e);
    return e ? (8'h01 << s) : 8'h00;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs, queue the outcome, then compare after the edge.
  task automatic step(input string name, input logic st, input logic sp,
                      input logic [2:0] es, input logic ee, input logic eb, input logic ed);
    exp_t e;
    exp_t g;
    start = st;
    stop  = sp;
    e.name = name;
    e.o    = {es, ee, eb, ed};
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check(g.name, {2'b00, sel, en, busy, done}, {2'b00, g.o});
    check({g.name, "_dec"}, dec(sel, en), dec(g.o[5:3], g.o[2]));
  endtask

  task automatic add_vec(input logic st, input logic [2:0] es, input logic ee,
                         input logic eb, input logic ed);
    vec_t v;
    v.start = st;  v.stop = 1'b0;  v.mode = 1'b0;
    v.mask  = 8'b1010_0101;  v.dwell = 8'd2;
    v.esel  = es;  v.een = ee;  v.ebusy = eb;  v.edone = ed;
    tbl.push_back(v);
  endtask

  initial begin
    logic [2:0] chs [4];
    chs[0] = 3'd0; chs[1] = 3'd2; chs[2] = 3'd5; chs[3] = 3'd7;

    // Scenario 1 table: three-cycle holds, one-cycle gaps, done after channel 7.
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 3; k++)
        add_vec((c == 0 && k == 0), chs[c], 1'b1, 1'b1, 1'b0);
      if (c < 3) add_vec(1'b0, chs[c+1], 1'b0, 1'b1, 1'b0);
      else       add_vec(1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
    end
    add_vec(1'b0, 3'd7, 1'b0, 1'b0, 1'b0);

    #12;
    check("reset_state", {2'b00, sel, en, busy, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      mode_cont = tbl[i].mode;
      ch_mask   = tbl[i].mask;
      dwell     = tbl[i].dwell;
      step($sformatf("single_pass_v%0d", i), tbl[i].start, tbl[i].stop,
           tbl[i].esel, tbl[i].een, tbl[i].ebusy, tbl[i].edone);
    end

    // Scenario 2: continuous wrap with dwell=0, then stop on channel 7.
    mode_cont = 1'b1; ch_mask = 8'b1000_0010; dwell = 8'd0;
    step("cont_a1",   1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
    step("cont_g7",   1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0);
    step("cont_a7",   1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0);
    step("cont_wrap", 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    step("cont_a1b",  1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
    step("cont_g7b",  1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0);
    step("cont_a7b",  1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0);
    step("cont_stop", 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    step("cont_idle", 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0);

    // Scenario 4: inputs changed and start re-pulsed mid-scan are ignored.
    mode_cont = 1'b0; ch_mask = 8'h11; dwell = 8'd1;
    step("shadow_a0",  1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    ch_mask = 8'hFF; dwell = 8'd5; mode_cont = 1'b1;
    step("shadow_a0b", 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    step("shadow_g4",  1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0);
    step("shadow_a4",  1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0);
    step("shadow_a4b", 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0);
    step("shadow_done",1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
    step("shadow_idle",1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);

    // Scenario 5: asynchronous reset between clock edges mid-ACTIVE.
    mode_cont = 1'b1; ch_mask = 8'h08; dwell = 8'd10;
    step("rst_a3",  1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
    step("rst_a3b", 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {2'b00, sel, en, busy, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      step($sformatf("post_rst_idle%0d", i), 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 6: start and stop together in IDLE.
    mode_cont = 1'b0; ch_mask = 8'hA5; dwell = 8'd2;
    step("start_stop",   1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    step("start_stop_2", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 3: empty mask gives a lone done pulse.
    ch_mask = 8'h00;
    step("empty_done",  1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    ch_mask = 8'hA5;
    step("empty_after", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("empty_idle",  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
